// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared types for the decode stage. Holds the opcode class
//               enum, the RV32I base opcodes, the decoded entry record used
//               for both pipeline slots, and the opcode classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    // Stored record widths. The top-level PC/immediate ports are cast to and
    // from these, so the stage is intended for PC_WIDTH/DATA_WIDTH <= 32.
    localparam int DEC_PC_W   = 32;
    localparam int DEC_DATA_W = 32;

    typedef enum logic [3:0] {
        LUI     = 4'd0,
        AUIPC   = 4'd1,
        JAL     = 4'd2,
        JALR    = 4'd3,
        BRANCH  = 4'd4,
        LOAD    = 4'd5,
        STORE   = 4'd6,
        OPIMM   = 4'd7,
        OP      = 4'd8,
        ILLEGAL = 4'd9
    } opclass_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [DEC_PC_W-1:0]   pc;
        logic [DEC_DATA_W-1:0] imm;
        opclass_e              opclass;
        logic [4:0]            rd;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic                  illegal;
    } decoded_t;

    // Full 7-bit compare: every legal opcode ends in 2'b11, so any word with
    // instr[1:0] != 2'b11 falls through to ILLEGAL.
    function automatic opclass_e classify(input logic [6:0] opcode);
        opclass_e oc;
        case (opcode)
            OPC_LUI:    oc = LUI;
            OPC_AUIPC:  oc = AUIPC;
            OPC_JAL:    oc = JAL;
            OPC_JALR:   oc = JALR;
            OPC_BRANCH: oc = BRANCH;
            OPC_LOAD:   oc = LOAD;
            OPC_STORE:  oc = STORE;
            OPC_OPIMM:  oc = OPIMM;
            OPC_OP:     oc = OP;
            default:    oc = ILLEGAL;
        endcase
        return oc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_if
// Description : Fetch-side and execute-side valid/ready bundle of the decode
//               stage. slave = the stage, master = fetch/execute neighbours.
//               Fetch side : in_valid_i, in_ready_o, in_instr_i, in_pc_i
//               Exec side  : out_valid_o, out_ready_i, out_* payload
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32
) ();

    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [31:0]           in_instr_i;
    logic [PC_WIDTH-1:0]   in_pc_i;

    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [PC_WIDTH-1:0]   out_pc_o;
    logic [DATA_WIDTH-1:0] out_imm_o;
    opclass_e              out_opclass_o;
    logic [4:0]            out_rd_o;
    logic [4:0]            out_rs1_o;
    logic [4:0]            out_rs2_o;
    logic [2:0]            out_funct3_o;
    logic [6:0]            out_funct7_o;
    logic                  out_illegal_o;

    modport slave (
        input  in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        output in_ready_o, out_valid_o, out_pc_o, out_imm_o, out_opclass_o,
               out_rd_o, out_rs1_o, out_rs2_o, out_funct3_o, out_funct7_o,
               out_illegal_o
    );

    modport master (
        output in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_pc_o, out_imm_o, out_opclass_o,
               out_rd_o, out_rs1_o, out_rs2_o, out_funct3_o, out_funct7_o,
               out_illegal_o
    );

endinterface
`default_nettype wire

// File: rtl/decode_stage_imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen
// Description : RV32I immediate generator. Builds the sign-extended
//               immediate for I/S/B/U/J formats; 0 for R-type and unknown
//               opcodes.
//               instr_i : raw 32-bit instruction word
//               imm_o   : DATA_WIDTH immediate
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic [31:0]           instr_i,
    output logic      [DATA_WIDTH-1:0] imm_o
);

    logic [31:0] w_imm32;

    always_comb begin
        w_imm32 = '0;
        case (instr_i[6:0])
            OPC_LUI, OPC_AUIPC:
                w_imm32 = {instr_i[31:12], 12'b0};
            OPC_JAL:
                w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
            OPC_JALR, OPC_LOAD, OPC_OPIMM:
                w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            OPC_STORE:
                w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            OPC_BRANCH:
                w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
            default:
                w_imm32 = '0;
        endcase
    end

    generate
        if (DATA_WIDTH > 32) begin : g_sext
            assign imm_o = {{(DATA_WIDTH-32){w_imm32[31]}}, w_imm32};
        end else begin : g_trunc
            assign imm_o = w_imm32[DATA_WIDTH-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Registered RV32I decode stage with a 2-entry skid buffer.
//               Decodes on capture, presents the main entry on out_*, keeps
//               in_ready_o straight off a flop, and supports flush.
//               clk_i, rst_i  : clock, synchronous active-high reset
//               flush_i       : drop both entries and same-cycle input
//               bus (slave)   : fetch-side and execute-side handshakes
//               decoded_cnt_o : count of output handshakes (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_i,
    input  wire logic                 flush_i,
    decode_stage_if.slave             bus,
    output logic      [CNT_WIDTH-1:0] decoded_cnt_o
);

    decoded_t              r_main;
    decoded_t              r_skid;
    logic                  r_main_valid;
    logic                  r_skid_valid;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic [DATA_WIDTH-1:0] w_imm;
    opclass_e              w_opclass;
    decoded_t              w_dec;
    logic                  w_in_fire;
    logic                  w_out_fire;

    imm_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm_gen (
        .instr_i (bus.in_instr_i),
        .imm_o   (w_imm)
    );

    // Decode the incoming word; only this record is stored.
    always_comb begin
        w_opclass      = classify(bus.in_instr_i[6:0]);
        w_dec          = '0;
        w_dec.pc       = DEC_PC_W'(bus.in_pc_i);
        w_dec.imm      = DEC_DATA_W'(w_imm);
        w_dec.opclass  = w_opclass;
        w_dec.rd       = bus.in_instr_i[11:7];
        w_dec.rs1      = bus.in_instr_i[19:15];
        w_dec.rs2      = bus.in_instr_i[24:20];
        w_dec.funct3   = bus.in_instr_i[14:12];
        w_dec.funct7   = bus.in_instr_i[31:25];
        w_dec.illegal  = (w_opclass == ILLEGAL);
    end

    // in_ready is the inverse of the skid flop, so no combinational path
    // from out_ready_i reaches in_ready_o.
    assign w_in_fire  = bus.in_valid_i & ~r_skid_valid;
    assign w_out_fire = r_main_valid & bus.out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_cnt        <= '0;
        end else begin
            // An output handshake in a flush cycle still completes.
            if (w_out_fire) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end

            if (flush_i) begin
                r_main_valid <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (!r_main_valid || w_out_fire) begin
                // Main slot frees up this cycle: refill from skid first to
                // keep ordering; with skid full, input is already blocked.
                if (r_skid_valid) begin
                    r_main       <= r_skid;
                    r_main_valid <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else begin
                    r_main_valid <= w_in_fire;
                    if (w_in_fire) begin
                        r_main <= w_dec;
                    end
                end
            end else if (w_in_fire) begin
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign bus.in_ready_o    = ~r_skid_valid;
    assign bus.out_valid_o   = r_main_valid;
    assign bus.out_pc_o      = PC_WIDTH'(r_main.pc);
    assign bus.out_imm_o     = DATA_WIDTH'(r_main.imm);
    assign bus.out_opclass_o = r_main.opclass;
    assign bus.out_rd_o      = r_main.rd;
    assign bus.out_rs1_o     = r_main.rs1;
    assign bus.out_rs2_o     = r_main.rs2;
    assign bus.out_funct3_o  = r_main.funct3;
    assign bus.out_funct7_o  = r_main.funct7;
    assign bus.out_illegal_o = r_main.illegal;
    assign decoded_cnt_o     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage (CNT_WIDTH=4 build).
//               Vector table of instructions with expected class/immediate,
//               a scoreboard queue of expected entries, and directed
//               sequences for backpressure, flush, reset and counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
    import decode_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        opclass_e    oc;
        logic [31:0] imm;
        logic        illegal;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [3:0]  oc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        illegal;
    } rec_t;

    localparam int NVEC = 14;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [3:0] cnt;

    int   total = 0;
    int   bad   = 0;
    bit   run   = 1'b0;
    rec_t q[$];
    rec_t cur_exp;
    logic [3:0] exp_cnt = '0;
    vec_t vecs [NVEC];

    decode_stage_if #(.DATA_WIDTH(32), .PC_WIDTH(32)) bus ();

    decode_stage #(
        .DATA_WIDTH (32),
        .PC_WIDTH   (32),
        .CNT_WIDTH  (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .bus           (bus.slave),
        .decoded_cnt_o (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    function automatic rec_t mk(input vec_t v);
        rec_t r;
        r.pc      = v.pc;
        r.imm     = v.imm;
        r.oc      = 4'(v.oc);
        r.rd      = v.instr[11:7];
        r.rs1     = v.instr[19:15];
        r.rs2     = v.instr[24:20];
        r.f3      = v.instr[14:12];
        r.f7      = v.instr[31:25];
        r.illegal = v.illegal;
        return r;
    endfunction

    function automatic rec_t got_rec();
        rec_t r;
        r.pc      = bus.out_pc_o;
        r.imm     = bus.out_imm_o;
        r.oc      = 4'(bus.out_opclass_o);
        r.rd      = bus.out_rd_o;
        r.rs1     = bus.out_rs1_o;
        r.rs2     = bus.out_rs2_o;
        r.f3      = bus.out_funct3_o;
        r.f7      = bus.out_funct7_o;
        r.illegal = bus.out_illegal_o;
        return r;
    endfunction

    // Scoreboard: the queue mirrors main+skid contents in order.
    always @(negedge clk) begin
        if (run) begin
            chk("out_valid", bus.out_valid_o, q.size() > 0);
            chk("in_ready", bus.in_ready_o, q.size() < 2);
            chk("decoded_cnt", cnt, exp_cnt);
            if (bus.out_valid_o && q.size() > 0)
                chk("payload", got_rec(), q[0]);
            if (rst) begin
                q.delete();
                exp_cnt = '0;
            end else begin
                if (bus.out_valid_o && bus.out_ready_i && q.size() > 0) begin
                    void'(q.pop_front());
                    exp_cnt = exp_cnt + 4'd1;
                end
                if (flush)
                    q.delete();
                else if (bus.in_valid_i && bus.in_ready_o)
                    q.push_back(cur_exp);
            end
        end
    end

    // Present vector idx until accepted or tries cycles pass.
    task automatic send(input int idx, input int tries, output bit ok);
        bus.in_valid_i = 1'b1;
        bus.in_instr_i = vecs[idx].instr;
        bus.in_pc_i    = vecs[idx].pc;
        cur_exp        = mk(vecs[idx]);
        ok = 1'b0;
        for (int t = 0; t < tries && !ok; t++) begin
            @(negedge clk);
            ok = bus.in_ready_o;
            @(posedge clk);
            #1;
        end
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", q.size() == 0, 1'b1);
    endtask

    initial begin
        bit ok;
        logic [3:0] snap;

        vecs[0]  = '{32'hFFF00093, 32'h100, OPIMM,   32'hFFFFFFFF, 1'b0};
        vecs[1]  = '{32'h123450B7, 32'h104, LUI,     32'h12345000, 1'b0};
        vecs[2]  = '{32'hFE000EE3, 32'h108, BRANCH,  32'hFFFFFFFC, 1'b0};
        vecs[3]  = '{32'h0000007F, 32'h10C, ILLEGAL, 32'h00000000, 1'b1};
        vecs[4]  = '{32'h00000000, 32'h110, ILLEGAL, 32'h00000000, 1'b1};
        vecs[5]  = '{32'h00A00513, 32'h114, OPIMM,   32'h0000000A, 1'b0};
        vecs[6]  = '{32'h008000EF, 32'h118, JAL,     32'h00000008, 1'b0};
        vecs[7]  = '{32'h00008067, 32'h11C, JALR,    32'h00000000, 1'b0};
        vecs[8]  = '{32'hFF812283, 32'h120, LOAD,    32'hFFFFFFF8, 1'b0};
        vecs[9]  = '{32'h00612623, 32'h124, STORE,   32'h0000000C, 1'b0};
        vecs[10] = '{32'hFFFFF297, 32'h128, AUIPC,   32'hFFFFF000, 1'b0};
        vecs[11] = '{32'h002081B3, 32'h12C, OP,      32'h00000000, 1'b0};
        vecs[12] = '{32'h12345671, 32'h130, ILLEGAL, 32'h00000000, 1'b1};
        vecs[13] = '{32'hFFC4A303, 32'h134, LOAD,    32'hFFFFFFFC, 1'b0};

        bus.in_valid_i  = 1'b0;
        bus.in_instr_i  = '0;
        bus.in_pc_i     = '0;
        bus.out_ready_i = 1'b0;
        cur_exp         = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid_o, 1'b0);
        chk("rst_in_ready", bus.in_ready_o, 1'b1);
        chk("rst_cnt", cnt, 4'd0);
        chk("rst_payload", got_rec(), '0);
        @(posedge clk);
        #1;
        run = 1'b1;

        // Table stream, full throughput
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            send(i, 4, ok);
            chk("table_accept", ok, 1'b1);
        end
        wait_empty();

        // Backpressure: main held, second to skid, third stalled
        bus.out_ready_i = 1'b0;
        send(0, 4, ok);
        chk("bp_accept0", ok, 1'b1);
        send(1, 4, ok);
        chk("bp_accept1", ok, 1'b1);
        send(2, 3, ok);
        chk("bp_third_stalled", ok, 1'b0);
        @(negedge clk);
        chk("bp_hold_pc", bus.out_pc_o, 32'h100);
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        send(2, 10, ok);
        chk("bp_accept2", ok, 1'b1);
        wait_empty();

        // Flush with both entries full and a same-cycle input
        bus.out_ready_i = 1'b0;
        send(3, 4, ok);
        send(4, 4, ok);
        snap = exp_cnt;
        bus.in_valid_i = 1'b1;
        bus.in_instr_i = vecs[5].instr;
        bus.in_pc_i    = vecs[5].pc;
        cur_exp        = mk(vecs[5]);
        flush          = 1'b1;
        @(posedge clk);
        #1;
        flush          = 1'b0;
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", bus.out_valid_o, 1'b0);
        chk("flush_in_ready", bus.in_ready_o, 1'b1);
        chk("flush_cnt", cnt, snap);
        @(posedge clk);
        #1;

        // Flush coinciding with an output handshake still counts it
        send(6, 4, ok);
        send(7, 4, ok);
        snap = exp_cnt;
        bus.out_ready_i = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_fire_cnt", cnt, snap + 4'd1);
        chk("flush_fire_valid", bus.out_valid_o, 1'b0);
        @(posedge clk);
        #1;
        send(8, 4, ok);
        chk("post_flush_accept", ok, 1'b1);
        wait_empty();

        // Reset mid-stream
        bus.out_ready_i = 1'b0;
        send(9, 4, ok);
        send(10, 4, ok);
        rst = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.in_instr_i = vecs[11].instr;
        bus.in_pc_i    = vecs[11].pc;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", bus.out_valid_o, 1'b0);
        chk("midrst_in_ready", bus.in_ready_o, 1'b1);
        chk("midrst_cnt", cnt, 4'd0);
        chk("midrst_payload", got_rec(), '0);
        @(posedge clk);
        #1;

        // Counter wrap: 15 transfers to all-ones, then one more to zero
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            send(i % NVEC, 4, ok);
            chk("wrap_accept", ok, 1'b1);
        end
        wait_empty();
        @(negedge clk);
        chk("cnt_all_ones", cnt, 4'hF);
        @(posedge clk);
        #1;
        send(1, 4, ok);
        wait_empty();
        @(negedge clk);
        chk("cnt_wrap_zero", cnt, 4'h0);
        @(posedge clk);
        #1;

        repeat (2) @(posedge clk);
        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
